// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, FSM states,
// ALU operations, datapath mux selects and the decoded instruction class.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WSRC_ALUOUT = 2'd0;
  localparam logic [1:0] WSRC_MDR    = 2'd1;
  localparam logic [1:0] WSRC_PC     = 2'd2;

  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_RALU,
    CLS_JR,
    CLS_LW,
    CLS_SW,
    CLS_ADDI,
    CLS_XORI,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL
  } instr_class_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] word);
    return word[5:0];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps the IR word to an instruction
// class and, for R-type arithmetic, the ALU operation taken from funct.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [31:0]        instr,
  output instr_class_t       cls,
  output logic [ALUOP_W-1:0] rtype_op
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = opcode_of(instr);
  assign funct         = funct_of(instr);
  assign unused_fields = ^instr[25:6];

  // Anything not listed falls through as CLS_NOP so the FSM can skip or trap it.
  always_comb begin
    cls      = CLS_NOP;
    rtype_op = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            cls      = CLS_RALU;
            rtype_op = ALUOP_W'(ALU_ADD);
          end
          FN_SUB: begin
            cls      = CLS_RALU;
            rtype_op = ALUOP_W'(ALU_SUB);
          end
          FN_SLT: begin
            cls      = CLS_RALU;
            rtype_op = ALUOP_W'(ALU_SLT);
          end
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_NOP;
        endcase
      end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_ADDI: cls = CLS_ADDI;
      OP_XORI: cls = CLS_XORI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM. Define MULTICYCLE_CTRL_TRAP_EN to send
// unsupported instructions to a sticky TRAP state and expose the trap port.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int WAIT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic [2:0]         state,
  output logic               pc_we,
  output logic               ir_we,
  output logic               a_we,
  output logic               b_we,
  output logic               reg_we,
  output logic               mem_re,
  output logic               mem_we,
  output logic               iord,
  output logic [1:0]         reg_dst,
  output logic [1:0]         reg_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic [WAIT_W-1:0]  wait_cnt
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,
  output logic               trap
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  instr_class_t       cls;
  logic [ALUOP_W-1:0] rtype_op;
  logic [2:0]         next_state;
  logic               mem_stall;

  ctrl_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .instr    (instr),
    .cls      (cls),
    .rtype_op (rtype_op)
  );

  assign mem_stall = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= '0;
      else if (mem_stall && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Outputs are gated by rst_n so an abort drops every strobe without waiting
  // for a clock edge.
  always_comb begin
    next_state = state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_dst    = DST_RT;
    reg_src    = WSRC_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    imm_zext   = 1'b0;
    alu_op     = ALUOP_W'(ALU_ADD);
    pc_src     = PCSRC_ALU;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    trap       = 1'b0;
`endif
    if (!rst_n) begin
      next_state = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            alu_src_b  = SRCB_FOUR;
            next_state = ST_DECODE;
          end
        end

        ST_DECODE: begin
          a_we      = 1'b1;
          b_we      = 1'b1;
          alu_src_b = SRCB_BOFF;
          case (cls)
            CLS_J: begin
              pc_we      = 1'b1;
              pc_src     = PCSRC_JUMP;
              next_state = ST_FETCH;
            end
            CLS_JAL: next_state = ST_WB;
            CLS_NOP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
              next_state = ST_TRAP;
`else
              next_state = ST_FETCH;
`endif
            end
            default: next_state = ST_EXEC;
          endcase
        end

        ST_EXEC: begin
          alu_src_a  = SRCA_A;
          next_state = ST_FETCH;
          case (cls)
            CLS_LW, CLS_SW: begin
              alu_src_b  = SRCB_IMM;
              next_state = ST_MEM;
            end
            CLS_RALU: begin
              alu_op     = rtype_op;
              next_state = ST_WB;
            end
            CLS_ADDI: begin
              alu_src_b  = SRCB_IMM;
              next_state = ST_WB;
            end
            CLS_XORI: begin
              alu_src_b  = SRCB_IMM;
              imm_zext   = 1'b1;
              alu_op     = ALUOP_W'(ALU_XOR);
              next_state = ST_WB;
            end
            CLS_BEQ, CLS_BNE: begin
              alu_op = ALUOP_W'(ALU_SUB);
              pc_we  = (cls == CLS_BEQ) ? alu_zero : !alu_zero;
              pc_src = PCSRC_ALUOUT;
            end
            CLS_JR: begin
              pc_we  = 1'b1;
              pc_src = PCSRC_REG;
            end
            default: next_state = ST_FETCH;
          endcase
        end

        ST_MEM: begin
          iord   = 1'b1;
          mem_re = (cls == CLS_LW);
          mem_we = (cls == CLS_SW);
          if (mem_ready)
            next_state = (cls == CLS_LW) ? ST_WB : ST_FETCH;
        end

        ST_WB: begin
          reg_we     = 1'b1;
          next_state = ST_FETCH;
          case (cls)
            CLS_RALU: reg_dst = DST_RD;
            CLS_LW:   reg_src = WSRC_MDR;
            CLS_JAL: begin
              reg_dst = DST_RA;
              reg_src = WSRC_PC;
              pc_we   = 1'b1;
              pc_src  = PCSRC_JUMP;
            end
            default: reg_dst = DST_RT;
          endcase
        end

`ifdef MULTICYCLE_CTRL_TRAP_EN
        ST_TRAP: begin
          trap       = 1'b1;
          next_state = ST_TRAP;
        end
`endif

        default: next_state = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model
// queues expected outputs per cycle; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int K_NOP  = 0;
  localparam int K_ALU  = 1;
  localparam int K_JR   = 2;
  localparam int K_LW   = 3;
  localparam int K_SW   = 4;
  localparam int K_ADDI = 5;
  localparam int K_XORI = 6;
  localparam int K_BEQ  = 7;
  localparam int K_BNE  = 8;
  localparam int K_J    = 9;
  localparam int K_JAL  = 10;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_we, ir_we, a_we, b_we, reg_we, mem_re, mem_we, iord;
    logic [1:0] reg_dst, reg_src, alu_src_a, alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] wait_cnt;
    logic       trap;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready, alu_zero;
  logic [2:0]  state;
  logic        pc_we, ir_we, a_we, b_we, reg_we, mem_re, mem_we, iord, imm_zext;
  logic [1:0]  reg_dst, reg_src, alu_src_a, alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  wait_cnt;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic        trap;
`endif

  outs_t exp_q[$];
  string tag_q[$];
  outs_t mon_exp;
  string mon_tag;
  int    checks = 0;
  int    fails  = 0;
  bit    mon_en = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .state     (state),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .a_we      (a_we),
    .b_we      (b_we),
    .reg_we    (reg_we),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .iord      (iord),
    .reg_dst   (reg_dst),
    .reg_src   (reg_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .imm_zext  (imm_zext),
    .alu_op    (alu_op),
    .pc_src    (pc_src),
    .wait_cnt  (wait_cnt)
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    .trap      (trap)
`endif
  );

  function automatic int classify(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    int         k;
    op = i[31:26];
    fn = i[5:0];
    k  = K_NOP;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) k = K_ALU;
        else if (fn == 6'h08) k = K_JR;
      end
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      6'h04: k = K_BEQ;
      6'h05: k = K_BNE;
      6'h08: k = K_ADDI;
      6'h0E: k = K_XORI;
      6'h23: k = K_LW;
      6'h2B: k = K_SW;
      default: k = K_NOP;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [31:0] i);
    logic [5:0] fn;
    fn = i[5:0];
    if (fn == 6'h22) return 3'd1;
    if (fn == 6'h2A) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [31:0] gen_instr(input int k);
    logic [31:0] i;
    logic [5:0]  fns[3];
    logic [5:0]  bad_ops[3];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h2A;
    bad_ops[0] = 6'h3F; bad_ops[1] = 6'h01; bad_ops[2] = 6'h00;
    i = $urandom;
    case (k)
      K_ALU:  begin i[31:26] = 6'h00; i[5:0] = fns[$urandom_range(0, 2)]; end
      K_JR:   begin i[31:26] = 6'h00; i[5:0] = 6'h08; end
      K_LW:   i[31:26] = 6'h23;
      K_SW:   i[31:26] = 6'h2B;
      K_ADDI: i[31:26] = 6'h08;
      K_XORI: i[31:26] = 6'h0E;
      K_BEQ:  i[31:26] = 6'h04;
      K_BNE:  i[31:26] = 6'h05;
      K_J:    i[31:26] = 6'h02;
      K_JAL:  i[31:26] = 6'h03;
      default: begin
        i[31:26] = bad_ops[$urandom_range(0, 2)];
        if (i[31:26] == 6'h00) i[5:0] = 6'h21;
      end
    endcase
    return i;
  endfunction

  function automatic outs_t base(input logic [2:0] st, input int wc);
    outs_t o;
    o          = '0;
    o.state    = st;
    o.wait_cnt = (wc > 15) ? 4'd15 : 4'(wc);
    return o;
  endfunction

  function automatic logic pickz(input int zsel);
    return (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
  endfunction

  task automatic applyStimulus(input logic [31:0] i, input logic rdy, input logic z,
                               input logic rst, input outs_t e, input string tag);
    @(posedge clk);
    #1;
    instr     = i;
    mem_ready = rdy;
    alu_zero  = z;
    rst_n     = rst;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input outs_t e, input string tag);
    outs_t a;
    a = '0;
    a.state = state; a.pc_we = pc_we; a.ir_we = ir_we; a.a_we = a_we; a.b_we = b_we;
    a.reg_we = reg_we; a.mem_re = mem_re; a.mem_we = mem_we; a.iord = iord;
    a.reg_dst = reg_dst; a.reg_src = reg_src; a.alu_src_a = alu_src_a;
    a.alu_src_b = alu_src_b; a.imm_zext = imm_zext; a.alu_op = alu_op;
    a.pc_src = pc_src; a.wait_cnt = wait_cnt;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    a.trap = trap;
`else
    a.trap = 1'b0;
`endif
    checks++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got state=%0d wait=%0d outs=%h, required state=%0d wait=%0d outs=%h",
               tag, $time, a.state, a.wait_cnt, a, e.state, e.wait_cnt, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL no_expectation at %0t: got state=%0d, required a queued entry", $time, state);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        checkOutput(mon_exp, mon_tag);
      end
    end
  end

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++)
      applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                    base(3'd0, 0), "reset");
  endtask

  // One instruction from FETCH to its return to FETCH, expressed as the list of
  // phases it visits with the outputs each phase requires.
  task automatic run_instr(input logic [31:0] i, input int fw, input int mw,
                           input int zsel, input bit abort_mem);
    int    k;
    outs_t e;
    logic  z;
    k = classify(i);

    for (int w = 0; w < fw; w++) begin
      e = base(3'd0, w); e.mem_re = 1'b1;
      applyStimulus(i, 1'b0, pickz(zsel), 1'b1, e, "fetch_wait");
    end
    e = base(3'd0, fw); e.mem_re = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
    applyStimulus(i, 1'b1, pickz(zsel), 1'b1, e, "fetch_done");

    e = base(3'd1, 0); e.a_we = 1'b1; e.b_we = 1'b1; e.alu_src_b = 2'd3;
    if (k == K_J) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
    applyStimulus(i, 1'($urandom_range(0, 1)), pickz(zsel), 1'b1, e, "decode");
    if (k == K_J) return;

    if (k == K_NOP) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
      for (int t = 0; t < 2; t++) begin
        e = base(3'd5, 0); e.trap = 1'b1;
        applyStimulus(i, 1'($urandom_range(0, 1)), pickz(zsel), 1'b1, e, "trap_hold");
      end
      do_reset(2);
`endif
      return;
    end

    if (k != K_JAL) begin
      z = pickz(zsel);
      e = base(3'd2, 0); e.alu_src_a = 2'd1;
      case (k)
        K_LW, K_SW, K_ADDI: e.alu_src_b = 2'd2;
        K_ALU:  e.alu_op = rtype_alu(i);
        K_XORI: begin e.alu_src_b = 2'd2; e.imm_zext = 1'b1; e.alu_op = 3'd2; end
        K_BEQ:  begin e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_we = z; end
        K_BNE:  begin e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_we = !z; end
        K_JR:   begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
        default: e = e;
      endcase
      applyStimulus(i, 1'($urandom_range(0, 1)), z, 1'b1, e, "exec");
      if (k == K_BEQ || k == K_BNE || k == K_JR) return;
    end

    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w < mw; w++) begin
        e = base(3'd3, w); e.iord = 1'b1;
        e.mem_re = (k == K_LW); e.mem_we = (k == K_SW);
        applyStimulus(i, 1'b0, pickz(zsel), 1'b1, e, "mem_wait");
        if (abort_mem) begin
          do_reset(2);
          return;
        end
      end
      e = base(3'd3, mw); e.iord = 1'b1;
      e.mem_re = (k == K_LW); e.mem_we = (k == K_SW);
      applyStimulus(i, 1'b1, pickz(zsel), 1'b1, e, "mem_done");
      if (k == K_SW) return;
    end

    e = base(3'd4, 0); e.reg_we = 1'b1;
    case (k)
      K_ALU: e.reg_dst = 2'd1;
      K_LW:  e.reg_src = 2'd1;
      K_JAL: begin e.reg_dst = 2'd2; e.reg_src = 2'd2; e.pc_we = 1'b1; e.pc_src = 2'd2; end
      default: e.reg_dst = 2'd0;
    endcase
    applyStimulus(i, 1'($urandom_range(0, 1)), pickz(zsel), 1'b1, e, "writeback");
  endtask

  initial begin
    rst_n     = 1'b0;
    instr     = '0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    mon_en    = 1'b1;

    do_reset(3);
    run_instr(32'h0022_1820, 0, 0, -1, 1'b0);                    // ADD $3,$1,$2
    run_instr({6'h23, 5'd4, 5'd5, 16'h0010}, 0, 3, -1, 1'b0);    // LW, 3 wait cycles
    run_instr({6'h05, 5'd1, 5'd2, 16'h0004}, 0, 0, 1, 1'b0);     // BNE, equal
    run_instr({6'h05, 5'd1, 5'd2, 16'h0004}, 0, 0, 0, 1'b0);     // BNE, not equal
    run_instr({6'h03, 26'h0123456}, 0, 0, -1, 1'b0);             // JAL
    run_instr({6'h02, 26'h0000040}, 0, 0, -1, 1'b0);             // J
    run_instr(gen_instr(K_ADDI), 20, 0, -1, 1'b0);               // long fetch stall
    run_instr({6'h2B, 5'd4, 5'd5, 16'h0008}, 0, 1, -1, 1'b1);    // SW aborted by reset
    run_instr({6'h3F, 26'h0}, 0, 0, -1, 1'b0);                   // unsupported opcode
    run_instr(gen_instr(K_JR), 1, 0, -1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      run_instr(gen_instr($urandom_range(0, 10)),
                ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 2),
                $urandom_range(0, 3), -1, 1'b0);
    end
    if ($urandom_range(0, 1) == 1) do_reset(1);
    run_instr(gen_instr(K_SW), 0, 2, -1, 1'b0);

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      #1;
    end
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
